// File: rtl/spi_flash_id_slave.sv
// SPI mode-0 slave answering the JEDEC read-ID command (9Fh).
// All SPI pins are synchronized into clk; the ID is shifted out on sck falls.
module spi_flash_id_slave #(
  parameter logic [7:0]  MANUF_ID = 8'hEF,
  parameter logic [15:0] DEV_ID   = 16'h4018
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       id_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RESP,
    IGNORE
  } state_t;

  localparam logic [7:0] RDID = 8'h9F;
  localparam logic [4:0] ID_BITS = 5'd24;

  state_t      state;
  state_t      state_nx;
  logic        cs_s1, cs_s2, cs_d;
  logic        sck_s1, sck_s2, sck_d;
  logic        mosi_s1, mosi_s2;
  logic        sck_rise, sck_fall;
  logic        cs_fall, cs_rise;
  logic [2:0]  bit_cnt;
  logic [4:0]  sent_cnt;
  logic [7:0]  rx;
  logic [7:0]  rx_nx;
  logic [23:0] tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  assign cs_rise  = cs_s2 & ~cs_d;
  assign rx_nx    = {rx[6:0], mosi_s2};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (cs_fall) state_nx = CMD;
        CMD:
          if (sck_rise && bit_cnt == 3'd7)
            state_nx = (rx_nx == RDID) ? RESP : IGNORE;
        RESP:   state_nx = RESP;
        IGNORE: state_nx = IGNORE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      id_done   <= 1'b0;
      bit_cnt   <= 3'd0;
      sent_cnt  <= 5'd0;
      rx        <= 8'h00;
      tx        <= 24'h0;
    end else begin
      cmd_valid <= 1'b0;
      id_done   <= 1'b0;
      // cs_n rise wins over any sck edge seen in the same cycle
      if (cs_rise) begin
        miso     <= 1'b0;
        bit_cnt  <= 3'd0;
        sent_cnt <= 5'd0;
      end else begin
        unique case (state)
          IDLE: begin
            miso <= 1'b0;
            if (cs_fall) begin
              bit_cnt <= 3'd0;
              rx      <= 8'h00;
            end
          end
          CMD: begin
            if (sck_rise) begin
              rx      <= rx_nx;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                cmd_byte  <= rx_nx;
                cmd_valid <= 1'b1;
                if (rx_nx == RDID) begin
                  tx       <= {MANUF_ID, DEV_ID};
                  sent_cnt <= 5'd0;
                end
              end
            end
          end
          RESP: begin
            if (sck_fall) begin
              if (sent_cnt != ID_BITS) begin
                miso     <= tx[23];
                tx       <= {tx[22:0], 1'b0};
                sent_cnt <= sent_cnt + 5'd1;
                if (sent_cnt == ID_BITS - 5'd1) id_done <= 1'b1;
              end else begin
                miso <= 1'b0;
              end
            end
          end
          IGNORE: miso <= 1'b0;
          default: miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_id_slave.sv
// Bench for spi_flash_id_slave: pin-level SPI master, two ID variants,
// behavioural expectations per transaction plus per-cycle idle/busy checks.
module tb_spi_flash_id_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso0, cv0, idd0, busy0;
  logic       miso1, cv1, idd1, busy1;
  logic [7:0] cb0, cb1;

  localparam logic [23:0] ID0 = 24'hEF4018;
  localparam logic [23:0] ID1 = 24'hC22018;

  int total = 0;
  int bad = 0;
  int cv_n0 = 0, cv_n1 = 0;
  int id_n0 = 0, id_n1 = 0;
  int cs_hi = 0;
  int cs_lo = 0;
  logic [7:0]  exp_cb = 8'h00;
  logic [63:0] rd0, rd1;

  spi_flash_id_slave dut0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck),
    .mosi(mosi), .miso(miso0), .cmd_valid(cv0),
    .cmd_byte(cb0), .id_done(idd0), .busy(busy0)
  );

  spi_flash_id_slave #(
    .MANUF_ID(8'hC2), .DEV_ID(16'h2018)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck),
    .mosi(mosi), .miso(miso1), .cmd_valid(cv1),
    .cmd_byte(cb1), .id_done(idd1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // What the master must read at sample k: zeros during the command
  // byte, then the ID MSB first for 9Fh, then zeros forever.
  function automatic logic exp_bit(input logic [23:0] id,
                                   input logic [7:0] cmd, input int k);
    logic [23:0] t;
    if (k < 8 || cmd != 8'h9F || k - 8 >= 24) return 1'b0;
    t = id << (k - 8);
    return t[23];
  endfunction

  function automatic logic [7:0] byte_at(input logic [63:0] rd,
                                         input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = rd[s+i];
    return b;
  endfunction

  // Pulse counters and per-cycle invariants, sampled 1 after posedge.
  always @(posedge clk) begin
    #1;
    if (cv0) cv_n0++;
    if (cv1) cv_n1++;
    if (idd0) id_n0++;
    if (idd1) id_n1++;
    cs_hi = cs_n ? cs_hi + 1 : 0;
    cs_lo = (!cs_n && rst_n) ? cs_lo + 1 : 0;
    if (cs_hi >= 3) begin
      chk("idle_miso0", miso0, 0);
      chk("idle_miso1", miso1, 0);
      chk("idle_busy0", busy0, 0);
      chk("idle_busy1", busy1, 0);
    end
    if (cs_lo >= 3) begin
      chk("sel_busy0", busy0, 1);
      chk("sel_busy1", busy1, 1);
    end
  end

  // Master samples miso at the end of each high phase.
  task automatic xfer(input logic [7:0] cmd, input int nbits,
                      input int half, input bit raise);
    int c0 = cv_n0;
    int c1 = cv_n1;
    int d0 = id_n0;
    int d1 = id_n1;
    rd0 = '0;
    rd1 = '0;
    cs_n = 1'b0;
    wait_clk(2 * half);
    for (int k = 0; k < nbits; k++) begin
      mosi = (k < 8) ? cmd[7-k] : 1'($urandom_range(0, 1));
      wait_clk(half);
      sck = 1'b1;
      wait_clk(half);
      rd0[k] = miso0;
      rd1[k] = miso1;
      chk("bit0", {k[15:0], 15'd0, miso0}, {k[15:0], 15'd0, exp_bit(ID0, cmd, k)});
      chk("bit1", {k[15:0], 15'd0, miso1}, {k[15:0], 15'd0, exp_bit(ID1, cmd, k)});
      sck = 1'b0;
    end
    if (raise) begin
      wait_clk(half);
      cs_n = 1'b1;
      wait_clk(6);
      if (nbits >= 8) exp_cb = cmd;
      chk("cv_cnt0", cv_n0 - c0, (nbits >= 8) ? 1 : 0);
      chk("cv_cnt1", cv_n1 - c1, (nbits >= 8) ? 1 : 0);
      chk("id_cnt0", id_n0 - d0, (cmd == 8'h9F && nbits - 7 >= 24) ? 1 : 0);
      chk("id_cnt1", id_n1 - d1, (cmd == 8'h9F && nbits - 7 >= 24) ? 1 : 0);
      chk("cmd_byte0", cb0, exp_cb);
      chk("cmd_byte1", cb1, exp_cb);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso0", miso0, 0);
    chk("rst_cv0", cv0, 0);
    chk("rst_idd0", idd0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_cb0", cb0, 8'h00);
    chk("rst_miso1", miso1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_cb1", cb1, 8'h00);
  endtask

  initial begin
    wait_clk(3);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);

    // read ID at clk/4
    xfer(8'h9F, 32, 2, 1'b1);
    chk("manuf0", byte_at(rd0, 8), 8'hEF);
    chk("dev_hi0", byte_at(rd0, 16), 8'h40);
    chk("dev_lo0", byte_at(rd0, 24), 8'h18);

    // non-ID command
    xfer(8'h03, 32, 2, 1'b1);

    // abort after 12 ID bits, then a full read
    xfer(8'h9F, 20, 2, 1'b1);
    xfer(8'h9F, 32, 2, 1'b1);
    chk("reread0", byte_at(rd0, 8), 8'hEF);

    // 40 clocks after command: trailing byte must be zero
    xfer(8'h9F, 48, 2, 1'b1);
    chk("tail0", byte_at(rd0, 32), 8'h00);

    // abort mid-command
    xfer(8'h9F, 5, 2, 1'b1);

    // reset mid-command
    xfer(8'h9F, 4, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    exp_cb = 8'h00;
    cs_n = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    xfer(8'h9F, 32, 2, 1'b1);
    chk("post_rst0", byte_at(rd0, 8), 8'hEF);

    // clk/8 against the alternate ID
    xfer(8'h9F, 32, 4, 1'b1);
    chk("manuf1", byte_at(rd1, 8), 8'hC2);
    chk("dev_hi1", byte_at(rd1, 16), 8'h20);
    chk("dev_lo1", byte_at(rd1, 24), 8'h18);

    for (int i = 0; i < 14; i++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h9F;
      xfer(c, int'($urandom_range(3, 48)), int'($urandom_range(2, 4)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_id_slave.md
SPI_FLASH_ID_SLAVE -- requirements
Module: spi_flash_id_slave

Interface
REQ-001 SHALL have parameter MANUF_ID, default 8'hEF, which is the JEDEC manufacturer ID byte returned first.
REQ-002 SHALL have parameter DEV_ID, default 16'h4018, which is the JEDEC device ID returned MSB byte first after MANUF_ID.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cs_n, input, 1 bit: SPI chip select from the master, active low, asynchronous to clk.
REQ-006 SHALL have port sck, input, 1 bit: SPI clock in mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-007 SHALL have port mosi, input, 1 bit: master-to-slave data, MSB first.
REQ-008 SHALL have port miso, output, 1 bit, registered: slave-to-master data, MSB first.
REQ-009 SHALL have port cmd_valid, output, 1 bit: one-clk pulse when a full command byte has been received.
REQ-010 SHALL have port cmd_byte, output, 8 bits: last received command byte, held until the next cmd_valid.
REQ-011 SHALL have port id_done, output, 1 bit: one-clk pulse when all 24 ID bits have been shifted out.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass cs_n, sck and mosi each through a 2-FF synchronizer, and SHALL detect sck rise/fall and cs_n fall/rise from the synchronized copies.
REQ-014 SHALL operate correctly when sck high and low phases are each at least 2 clk periods, i.e. sck = clk/4 or slower.
REQ-015 SHALL implement states IDLE, CMD, RESP and IGNORE.
REQ-016 SHALL leave IDLE for CMD on a synced cs_n fall, clearing the bit counter (3 bits) and the receive shift register.
REQ-017 SHALL, in CMD, shift the synced mosi into the LSB of the receive register on each synced sck rise.
REQ-018 SHALL, on the 8th rise in CMD, set cmd_byte to the received byte and pulse cmd_valid in the following cycle.
REQ-019 SHALL, on that 8th rise, enter RESP if the byte is 8'h9F and enter IGNORE otherwise.
REQ-020 SHALL, on entering RESP, load a 24-bit transmit register with {MANUF_ID, DEV_ID} and clear a 5-bit sent-bit counter.
REQ-021 SHALL, in RESP, drive miso with transmit-register bit 23 on each synced sck fall, then shift the register left and increment the counter.
REQ-022 SHALL require the first ID bit to appear on miso after the sck fall that follows the 8th command rise.
REQ-023 SHALL bound the miso update latency to at most 3 clk after the pin-level sck fall (2 for sync, 1 for the register).
REQ-024 SHALL, after the 24th bit, pulse id_done once, drive miso 0 for all further falls, and remain in RESP until cs_n rises.
REQ-025 SHALL, in IGNORE, hold miso at 0 and ignore sck until cs_n rises.
REQ-026 SHALL, on a synced cs_n rise in any state, return to IDLE within 1 clk, force miso to 0 and clear both counters.
REQ-027 SHALL NOT pulse cmd_valid or id_done on an abort mid-byte or mid-ID.
REQ-028 SHALL give cs_n rise priority when a cs_n rise and an sck edge are detected in the same clk.
REQ-029 SHALL ignore sck edges while in IDLE.
REQ-030 SHALL keep miso at 0 whenever cs_n is high; there is no tristate, since the slave is the sole driver on the PL net.

Reset
REQ-031 SHALL, while rst_n is low, set state to IDLE, and set miso, cmd_valid, id_done and busy to 0, cmd_byte to 8'h00, counters and shift registers to 0, and synchronizer stages for cs_n to 1 and for sck/mosi to 0.
REQ-032 SHALL, when reset is asserted mid-transfer, take effect immediately, and the block SHALL wait for a fresh cs_n fall after release before responding.

Verification
REQ-033 SHALL cover: master at sck=clk/4 sends 8'h9F then 24 clocks -> cmd_valid with cmd_byte=8'h9F, master samples 8'hEF, 8'h40, 8'h18, id_done pulses once.
REQ-034 SHALL cover: command 8'h03 followed by 24 clocks -> cmd_byte=8'h03, miso constantly 0, no id_done, busy high until cs_n rises.
REQ-035 SHALL cover: cs_n raised after 12 ID bits -> IDLE within 3 clk, miso=0, no id_done; the next 8'h9F transaction returns the full ID from bit 23.
REQ-036 SHALL cover: 40 sck cycles after 8'h9F -> bits 25..32 read as 8'h00, and id_done pulses exactly once.
REQ-037 SHALL cover: rst_n pulsed low mid-command -> all outputs at reset values; a new cs_n fall and 8'h9F read is correct.
REQ-038 SHALL cover: sck at clk/8 with MANUF_ID=8'hC2 and DEV_ID=16'h2018 -> master reads 8'hC2, 8'h20, 8'h18.
